// File: rtl/axil_pkg.sv
// Shared AXI4-lite bridge definitions: response codes, FSM states, address helpers.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WACC  = 3'd1,
    ST_WRESP = 3'd2,
    ST_RACC  = 3'd3,
    ST_RRESP = 3'd4
  } bridge_state_t;

  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } rr_dir_t;

  // Byte address to word address; caller truncates to the RAM address width.
  function automatic logic [63:0] word_addr(input logic [63:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

  // True when no bit at or above position hi is set.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned hi);
    return (addr >> hi) == 64'd0;
  endfunction

endpackage

// File: rtl/axil_ram_bridge.sv
// AXI4-lite slave converting byte-addressed read/write transactions into
// single-word accesses on one native RAM port; one transaction outstanding.
module axil_ram_bridge
  import axil_pkg::*;
#(
  parameter int unsigned AXI_ADDRW = 32,
  parameter int unsigned ADDRW     = 8,
  parameter int unsigned DATAW     = 32,
  parameter int unsigned AXI_IDW   = 4
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [AXI_ADDRW-1:0] awaddr,
  input  logic [2:0]           awprot,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATAW-1:0]     wdata,
  input  logic [DATAW/8-1:0]   wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [AXI_ADDRW-1:0] araddr,
  input  logic [2:0]           arprot,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATAW-1:0]     rdata,
  output logic [1:0]           rresp,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDRW-1:0]     mem_addr,
  output logic [DATAW-1:0]     mem_wdata,
  output logic [DATAW/8-1:0]   mem_strb,
  input  logic [DATAW-1:0]     mem_rdata,
  input  logic                 mem_ready
);

  localparam int unsigned STRBW = DATAW / 8;
  localparam int unsigned B     = $clog2(STRBW);

  bridge_state_t        state_q,     state_d;
  rr_dir_t              rr_last_q,   rr_last_d;
  logic                 aw_full_q,   aw_full_d;
  logic                 w_full_q,    w_full_d;
  logic                 ar_full_q,   ar_full_d;
  logic [AXI_ADDRW-1:0] aw_addr_q,   aw_addr_d;
  logic [AXI_ADDRW-1:0] ar_addr_q,   ar_addr_d;
  logic [DATAW-1:0]     w_data_q,    w_data_d;
  logic [STRBW-1:0]     w_strb_q,    w_strb_d;
  logic                 awready_q,   awready_d;
  logic                 wready_q,    wready_d;
  logic                 arready_q,   arready_d;
  logic                 bvalid_q,    bvalid_d;
  logic [1:0]           bresp_q,     bresp_d;
  logic                 rvalid_q,    rvalid_d;
  logic [DATAW-1:0]     rdata_q,     rdata_d;
  logic [1:0]           rresp_q,     rresp_d;
  logic                 mem_en_q,    mem_en_d;
  logic                 mem_wr_q,    mem_wr_d;
  logic [ADDRW-1:0]     mem_addr_q,  mem_addr_d;
  logic [DATAW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [STRBW-1:0]     mem_strb_q,  mem_strb_d;

  logic aw_hs, w_hs, ar_hs;
  logic w_req, r_req, grant_w, grant_r;
  logic aw_ok, ar_ok;
  logic unused_ok;

  assign aw_hs   = awvalid && awready_q;
  assign w_hs    = wvalid && wready_q;
  assign ar_hs   = arvalid && arready_q;
  assign w_req   = aw_full_q && w_full_q;
  assign r_req   = ar_full_q;
  // On conflict the direction not granted last wins.
  assign grant_w = w_req && (!r_req || (rr_last_q == RR_READ));
  assign grant_r = r_req && !grant_w;
  assign aw_ok   = addr_in_range(64'(aw_addr_q), ADDRW + B);
  assign ar_ok   = addr_in_range(64'(ar_addr_q), ADDRW + B);

  assign unused_ok = ^{awprot, arprot, RESP_SLVERR, 32'(AXI_IDW)};

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    aw_full_d   = aw_full_q;
    w_full_d    = w_full_q;
    ar_full_d   = ar_full_q;
    aw_addr_d   = aw_addr_q;
    ar_addr_d   = ar_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = araddr;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_w) begin
          rr_last_d = RR_WRITE;
          if (aw_ok) begin
            state_d     = ST_WACC;
            mem_en_d    = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = ADDRW'(word_addr(64'(aw_addr_q), B));
            mem_wdata_d = w_data_q;
            mem_strb_d  = w_strb_q;
          end else begin
            state_d  = ST_WRESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_DECERR;
          end
        end else if (grant_r) begin
          rr_last_d = RR_READ;
          if (ar_ok) begin
            state_d    = ST_RACC;
            mem_en_d   = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = ADDRW'(word_addr(64'(ar_addr_q), B));
            mem_strb_d = '0;
          end else begin
            state_d  = ST_RRESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
          end
        end
      end
      ST_WACC: begin
        if (mem_ready) begin
          state_d  = ST_WRESP;
          mem_en_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
        end
      end
      ST_RACC: begin
        if (mem_ready) begin
          state_d  = ST_RRESP;
          mem_en_d = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rdata_d  = mem_rdata;
        end
      end
      ST_WRESP: begin
        if (bready) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      ST_RRESP: begin
        if (rready) begin
          state_d   = ST_IDLE;
          rvalid_d  = 1'b0;
          ar_full_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Readies are registered from next-cycle slot/state so they never depend on bready/rready combinationally.
    awready_d = !aw_full_d && (state_d != ST_WACC) && (state_d != ST_WRESP);
    wready_d  = !w_full_d && (state_d != ST_WACC) && (state_d != ST_WRESP);
    arready_d = (state_d == ST_IDLE) && !ar_full_d;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= RR_READ;
      aw_full_q   <= 1'b0;
      w_full_q    <= 1'b0;
      ar_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      aw_full_q   <= aw_full_d;
      w_full_q    <= w_full_d;
      ar_full_q   <= ar_full_d;
      aw_addr_q   <= aw_addr_d;
      ar_addr_q   <= ar_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign arready   = arready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_strb  = mem_strb_q;

endmodule

// File: tb/tb_axil_ram_bridge.sv
// Bench for axil_ram_bridge: behavioural RAM port, reference memory and response scoreboard.
module tb_axil_ram_bridge;

  logic        aclk = 1'b0;
  logic        srst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        mem_en, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_pulses = 0;
  logic en_prev = 1'b0;

  logic [31:0] ram     [256];
  int          wr_cnt  [256];
  logic [31:0] ref_mem [256];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  axil_ram_bridge #(.AXI_ADDRW(32), .ADDRW(8), .DATAW(32), .AXI_IDW(4)) dut (
    .aclk(aclk), .srst(srst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc     <= cyc + 1;
    en_prev <= mem_en;
    if (mem_en && !en_prev) en_pulses <= en_pulses + 1;
  end

  // RAM port: one-cycle ready pulse the cycle after mem_en, no retrigger during ready.
  always @(posedge aclk) begin
    mem_ready <= mem_en && !mem_ready;
    if (mem_en && !mem_ready) begin
      if (mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (mem_strb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a >> 10) == 32'd0;
  endfunction

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [7:0] idx;
    idx = addr[9:2];
    if (in_rng(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      exp_b_q.push_back(2'b00);
    end else begin
      exp_b_q.push_back(2'b11);
    end
  endtask

  task automatic push_read(input logic [31:0] addr);
    logic [7:0] idx;
    idx = addr[9:2];
    if (in_rng(addr)) exp_r_q.push_back({2'b00, ref_mem[idx]});
    else              exp_r_q.push_back({2'b11, 32'h0});
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, output int hs_cyc, output logic w_leak);
    logic aw_done, w_done, aw_hs, w_hs;
    int t;
    aw_done = 0; w_done = 0; w_leak = 0; t = 0; hs_cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    wvalid = 1'b1;
    awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && t < 100) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (w_done && !aw_done && wready) w_leak = 1'b1;
      step();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      t++;
      if (!aw_done && t >= w_lead) awvalid = 1'b1;
    end
    hs_cyc = cyc;
    if (!(aw_done && w_done)) begin
      n_checks++; n_fail++;
      $display("FAIL write_handshake addr=%h aw_done=%0b w_done=%0b required both", addr, aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      push_write(addr, data, strb);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output int hs_cyc);
    logic hs, done;
    int t;
    done = 0; t = 0;
    araddr = addr; arvalid = 1'b1;
    while (!done && t < 100) begin
      hs = arvalid && arready;
      step();
      if (hs) begin arvalid = 1'b0; done = 1'b1; end
      t++;
    end
    hs_cyc = cyc;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL read_handshake addr=%h timed out", addr);
      arvalid = 1'b0;
    end else begin
      push_read(addr);
    end
  endtask

  // Consume responses until the scoreboard is empty; reports cycle each response was seen.
  task automatic drain(output int b_cyc, output int r_cyc);
    logic [1:0]  eb;
    logic [33:0] er;
    int t;
    b_cyc = -1; r_cyc = -1; t = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && t < 200) begin
      if (bvalid) begin
        n_checks++;
        if (exp_b_q.size() == 0) begin
          n_fail++; $display("FAIL bresp_unexpected got bvalid with nothing expected");
        end else begin
          eb = exp_b_q.pop_front();
          if (bresp !== eb) begin
            n_fail++; $display("FAIL bresp got %b required %b", bresp, eb);
          end
        end
        b_cyc = cyc;
      end
      if (rvalid) begin
        n_checks++;
        if (exp_r_q.size() == 0) begin
          n_fail++; $display("FAIL rresp_unexpected got rvalid with nothing expected");
        end else begin
          er = exp_r_q.pop_front();
          if ({rresp, rdata} !== er) begin
            n_fail++; $display("FAIL rdata got resp=%b data=%h required resp=%b data=%h",
                               rresp, rdata, er[33:32], er[31:0]);
          end
        end
        r_cyc = cyc;
      end
      step();
      t++;
    end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout b_left=%0d r_left=%0d required 0", exp_b_q.size(), exp_r_q.size());
      exp_b_q.delete(); exp_r_q.delete();
    end
  endtask

  function automatic logic [113:0] all_outs();
    return {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
            mem_en, mem_wr, mem_addr, mem_wdata, mem_strb};
  endfunction

  task automatic test_reset();
    srst = 1'b1;
    step(); step();
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h required 0", all_outs());
    end
    srst = 1'b0;
    step(); step();
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_readies got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_read();
    int hs, bc, rc, p0;
    logic leak;
    p0 = en_pulses;
    axi_write(32'h100, 32'hDEADBEEF, 4'hF, 0, hs, leak);
    drain(bc, rc);
    n_checks++;
    if (bc - hs != 3) begin
      n_fail++; $display("FAIL write_latency got %0d required 3", bc - hs);
    end
    n_checks++;
    if (en_pulses - p0 != 1) begin
      n_fail++; $display("FAIL write_en_pulses got %0d required 1", en_pulses - p0);
    end
    p0 = en_pulses;
    axi_read(32'h100, hs);
    drain(bc, rc);
    n_checks++;
    if (rc - hs != 3) begin
      n_fail++; $display("FAIL read_latency got %0d required 3", rc - hs);
    end
    n_checks++;
    if (en_pulses - p0 != 1) begin
      n_fail++; $display("FAIL read_en_pulses got %0d required 1", en_pulses - p0);
    end
  endtask

  task automatic test_w_before_aw();
    int hs, bc, rc, w0;
    logic leak;
    w0 = wr_cnt[1];
    axi_write(32'h004, 32'h12345678, 4'hF, 3, hs, leak);
    n_checks++;
    if (leak !== 1'b0) begin
      n_fail++; $display("FAIL wready_after_capture got 1 required 0");
    end
    drain(bc, rc);
    n_checks++;
    if (wr_cnt[1] - w0 != 1) begin
      n_fail++; $display("FAIL word1_writes got %0d required 1", wr_cnt[1] - w0);
    end
    axi_read(32'h004, hs);
    drain(bc, rc);
  endtask

  task automatic test_partial_write();
    int hs, bc, rc;
    logic leak;
    axi_write(32'h100, 32'h0000CAFE, 4'h3, 0, hs, leak);
    drain(bc, rc);
    axi_read(32'h100, hs);
    drain(bc, rc);
  endtask

  task automatic test_conflict();
    int hs, bc, rc;
    logic leak;
    srst = 1'b1; step(); srst = 1'b0; step(); step();
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) begin
        // Last grant was the read; a lone write makes the write the last grant.
        axi_write(32'h108, 32'h0BADF00D, 4'hF, 0, hs, leak);
        drain(bc, rc);
      end
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
        n_fail++; $display("FAIL conflict_readies rep=%0d got %b required 111", rep, {awready, wready, arready});
      end
      awaddr = 32'h104; wdata = 32'hC0FFEE00 + 32'(rep); wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h100; arvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      push_write(32'h104, 32'hC0FFEE00 + 32'(rep), 4'hF);
      push_read(32'h100);
      drain(bc, rc);
      n_checks++;
      if ((rep == 0 && !(bc >= 0 && bc < rc)) || (rep == 1 && !(rc >= 0 && rc < bc))) begin
        n_fail++; $display("FAIL conflict_order rep=%0d got b_cyc=%0d r_cyc=%0d required %s first",
                           rep, bc, rc, (rep == 0) ? "write" : "read");
      end
    end
  endtask

  task automatic test_out_of_range();
    int hs, bc, rc, p0;
    logic leak;
    p0 = en_pulses;
    axi_write(32'h400, 32'h55AA55AA, 4'hF, 0, hs, leak);
    drain(bc, rc);
    axi_read(32'h400, hs);
    drain(bc, rc);
    n_checks++;
    if (en_pulses != p0) begin
      n_fail++; $display("FAIL oor_mem_en got %0d pulses required 0", en_pulses - p0);
    end
  endtask

  task automatic test_random();
    int hs, bc, rc;
    logic leak;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      axi_write(a, $urandom, 4'($urandom_range(1, 15)), i % 2, hs, leak);
      drain(bc, rc);
      axi_read(a, hs);
      drain(bc, rc);
    end
  endtask

  task automatic test_backpressure_reset();
    int hs, t;
    logic leak, stable;
    logic [1:0] eb;
    bready = 1'b0;
    axi_write(32'h10C, 32'hA5A5A5A5, 4'hF, 0, hs, leak);
    t = 0;
    while (!bvalid && t < 20) begin step(); t++; end
    n_checks++;
    if (!bvalid) begin
      n_fail++; $display("FAIL bvalid_timeout got 0 required 1");
    end
    eb = exp_b_q.pop_front();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bvalid !== 1'b1 || bresp !== eb) stable = 1'b0;
      step();
    end
    n_checks++;
    if (!stable) begin
      n_fail++; $display("FAIL bvalid_hold got unstable required 10 cycles of bresp=%b", eb);
    end
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== eb) begin
      n_fail++; $display("FAIL bresp_after_hold got v=%b r=%b required v=1 r=%b", bvalid, bresp, eb);
    end
    bready = 1'b1;
    step();
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL bvalid_release got 1 required 0");
    end
    axi_read(32'h100, hs);
    t = 0;
    while (!mem_en && t < 20) begin step(); t++; end
    n_checks++;
    if (!mem_en) begin
      n_fail++; $display("FAIL racc_timeout got mem_en=0 required 1");
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    exp_r_q.delete();
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got %h required 0", all_outs());
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rvalid !== 1'b0) stable = 1'b0;
      step();
    end
    n_checks++;
    if (!stable) begin
      n_fail++; $display("FAIL rvalid_after_reset got 1 required never");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'(i) * 32'h01010101;
      ref_mem[i] = 32'(i) * 32'h01010101;
      wr_cnt[i] = 0;
    end
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_partial_write();
    test_conflict();
    test_out_of_range();
    test_random();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
